// File: rtl/sw_seq_loader.sv
// sw_seq_loader: packs a UART byte stream (2-byte length header followed by
// 2-bit-per-base payload, MSB first) into one Smith-Waterman job for SW_core.
module sw_seq_loader #(
   parameter int unsigned MAX_LENGTH = 128,
   parameter int unsigned LEN_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              i_byte,
   input  logic                    i_byte_valid,
   output logic                    o_byte_ready,
   output logic                    o_valid,
   input  logic                    i_ready,
   output logic [2*MAX_LENGTH-1:0] o_sequence_ref,
   output logic [2*MAX_LENGTH-1:0] o_sequence_read,
   output logic [LEN_W-1:0]        o_seq_ref_length,
   output logic [LEN_W-1:0]        o_seq_read_length,
   output logic                    o_err
);

   localparam int unsigned SEQ_W = 2 * MAX_LENGTH;
   localparam logic [8:0]  MaxLen = 9'(MAX_LENGTH);

   typedef enum logic [2:0] {
      S_HDR_REF,
      S_HDR_READ,
      S_REF,
      S_READ,
      S_OUT
   } state_t;

   state_t             state_q, state_d;
   logic [SEQ_W-1:0]   ref_q, ref_d;
   logic [SEQ_W-1:0]   read_q, read_d;
   logic [LEN_W-1:0]   ref_len_q, ref_len_d;
   logic [LEN_W-1:0]   read_len_q, read_len_d;
   logic [5:0]         cnt_q, cnt_d;
   logic               err_q, err_d;

   logic               xfer;
   logic               hdr_ok;
   logic [LEN_W:0]     cnt_ext;
   logic [LEN_W:0]     ref_last;
   logic [LEN_W:0]     read_last;
   logic [SEQ_W-1:0]   byte_placed;

   // Datapath helpers: transfer strobe, header legality, last-byte indices and
   // the incoming byte shifted into slot cnt_q (sequence regs are pre-cleared,
   // so OR-ing it in is equivalent to a part-select write).
   always_comb begin
      xfer        = i_byte_valid && (state_q != S_OUT);
      hdr_ok      = (i_byte != 8'd0) && ({1'b0, i_byte} <= MaxLen);
      cnt_ext     = (LEN_W + 1)'(cnt_q);
      ref_last    = (({1'b0, ref_len_q} + (LEN_W + 1)'(3)) >> 2) - (LEN_W + 1)'(1);
      read_last   = (({1'b0, read_len_q} + (LEN_W + 1)'(3)) >> 2) - (LEN_W + 1)'(1);
      byte_placed = {i_byte, {(SEQ_W - 8){1'b0}}} >> {cnt_q, 3'b000};
   end

   // Next-state logic: header parsing, payload assembly and job handshake.
   always_comb begin
      state_d    = state_q;
      ref_d      = ref_q;
      read_d     = read_q;
      ref_len_d  = ref_len_q;
      read_len_d = read_len_q;
      cnt_d      = cnt_q;
      err_d      = 1'b0;
      case (state_q)
         S_HDR_REF: begin
            if (xfer) begin
               if (hdr_ok) begin
                  ref_len_d = LEN_W'(i_byte);
                  ref_d     = '0;
                  read_d    = '0;
                  state_d   = S_HDR_READ;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_HDR_READ: begin
            if (xfer) begin
               if (hdr_ok) begin
                  read_len_d = LEN_W'(i_byte);
                  cnt_d      = 6'd0;
                  state_d    = S_REF;
               end else begin
                  // Whole frame is dropped; resync on the next H0.
                  err_d   = 1'b1;
                  state_d = S_HDR_REF;
               end
            end
         end
         S_REF: begin
            if (xfer) begin
               ref_d = ref_q | byte_placed;
               if (cnt_ext == ref_last) begin
                  cnt_d   = 6'd0;
                  state_d = S_READ;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         S_READ: begin
            if (xfer) begin
               read_d = read_q | byte_placed;
               if (cnt_ext == read_last) begin
                  state_d = S_OUT;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         S_OUT: begin
            if (i_ready) begin
               state_d = S_HDR_REF;
            end
         end
         default: state_d = S_HDR_REF;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_HDR_REF;
         ref_q      <= '0;
         read_q     <= '0;
         ref_len_q  <= '0;
         read_len_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_q      <= ref_d;
         read_q     <= read_d;
         ref_len_q  <= ref_len_d;
         read_len_q <= read_len_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   // Outputs decoded from registers only.
   always_comb begin
      o_byte_ready      = (state_q != S_OUT);
      o_valid           = (state_q == S_OUT);
      o_sequence_ref    = ref_q;
      o_sequence_read   = read_q;
      o_seq_ref_length  = ref_len_q;
      o_seq_read_length = read_len_q;
      o_err             = err_q;
   end

endmodule

// File: tb/tb_sw_seq_loader.sv
// Directed bench for sw_seq_loader: frames are modelled into a job scoreboard
// when sent and popped/compared when the loader presents o_valid.
module tb_sw_seq_loader;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   i_byte = 8'h00;
   logic         i_byte_valid = 1'b0;
   logic         i_ready = 1'b0;
   logic         o_byte_ready;
   logic         o_valid;
   logic [255:0] o_sequence_ref;
   logic [255:0] o_sequence_read;
   logic [7:0]   o_seq_ref_length;
   logic [7:0]   o_seq_read_length;
   logic         o_err;

   typedef struct {
      logic [255:0] r;
      logic [255:0] d;
      logic [7:0]   rl;
      logic [7:0]   dl;
   } job_t;

   job_t       sb[$];
   logic [7:0] ref_bytes[32];
   logic [7:0] read_bytes[32];
   int         n_vec = 0;
   int         n_err = 0;

   sw_seq_loader #(.MAX_LENGTH(128), .LEN_W(8)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_byte            (i_byte),
      .i_byte_valid      (i_byte_valid),
      .o_byte_ready      (o_byte_ready),
      .o_valid           (o_valid),
      .i_ready           (i_ready),
      .o_sequence_ref    (o_sequence_ref),
      .o_sequence_read   (o_sequence_read),
      .o_seq_ref_length  (o_seq_ref_length),
      .o_seq_read_length (o_seq_read_length),
      .o_err             (o_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte; returns at the falling edge after the transfer edge.
   task automatic put(input logic [7:0] b);
      i_byte       = b;
      i_byte_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle();
      i_byte_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_frame(input int h0, input int h1, input bit gap);
      job_t       j;
      logic [7:0] fb[66];
      int         nr;
      int         nd;
      int         n;
      nr   = (h0 + 3) >> 2;
      nd   = (h1 + 3) >> 2;
      j.r  = '0;
      j.d  = '0;
      j.rl = 8'(h0);
      j.dl = 8'(h1);
      for (int k = 0; k < nr; k++) j.r[255-8*k -: 8] = ref_bytes[k];
      for (int k = 0; k < nd; k++) j.d[255-8*k -: 8] = read_bytes[k];
      sb.push_back(j);
      fb[0] = 8'(h0);
      fb[1] = 8'(h1);
      n = 2;
      for (int k = 0; k < nr; k++) begin fb[n] = ref_bytes[k]; n++; end
      for (int k = 0; k < nd; k++) begin fb[n] = read_bytes[k]; n++; end
      for (int i = 0; i < n; i++) begin
         if (gap && i > 0) idle();
         put(fb[i]);
      end
      i_byte_valid = 1'b0;
   endtask

   // Called right after send_frame: o_valid must already be up.
   task automatic pop_check(input string tag, output job_t j);
      chk({tag, "_valid_latency"}, 256'(o_valid), 256'd1);
      chk({tag, "_byte_ready"}, 256'(o_byte_ready), 256'd0);
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s_scoreboard: observed empty queue expected a job", tag);
         j.r  = '0;
         j.d  = '0;
         j.rl = '0;
         j.dl = '0;
      end else begin
         j = sb.pop_front();
         chk({tag, "_ref"}, o_sequence_ref, j.r);
         chk({tag, "_read"}, o_sequence_read, j.d);
         chk({tag, "_ref_len"}, 256'(o_seq_ref_length), 256'(j.rl));
         chk({tag, "_read_len"}, 256'(o_seq_read_length), 256'(j.dl));
      end
   endtask

   task automatic handshake(input string tag);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      chk({tag, "_hs_valid"}, 256'(o_valid), 256'd0);
      chk({tag, "_hs_ready"}, 256'(o_byte_ready), 256'd1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_ready"}, 256'(o_byte_ready), 256'd1);
      chk({tag, "_valid"}, 256'(o_valid), 256'd0);
      chk({tag, "_err"}, 256'(o_err), 256'd0);
      chk({tag, "_ref"}, o_sequence_ref, 256'd0);
      chk({tag, "_read"}, o_sequence_read, 256'd0);
      chk({tag, "_ref_len"}, 256'(o_seq_ref_length), 256'd0);
      chk({tag, "_read_len"}, 256'(o_seq_read_length), 256'd0);
   endtask

   initial begin
      job_t j;

      // Reset state
      repeat (2) @(negedge clk);
      check_reset_values("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic 4/4 frame
      ref_bytes[0]  = 8'h1B;
      read_bytes[0] = 8'hE4;
      send_frame(4, 4, 1'b0);
      pop_check("f44", j);
      handshake("f44");

      // Full 128/128 frame, core stalls 10 cycles while a byte is offered
      for (int k = 0; k < 32; k++) begin
         ref_bytes[k]  = 8'(k);
         read_bytes[k] = 8'(8'hFF - k);
      end
      send_frame(128, 128, 1'b0);
      pop_check("full", j);
      i_byte       = 8'h55;
      i_byte_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("full_hold_valid", 256'(o_valid), 256'd1);
         chk("full_hold_ready", 256'(o_byte_ready), 256'd0);
         chk("full_hold_ref", o_sequence_ref, j.r);
         chk("full_hold_read", o_sequence_read, j.d);
         chk("full_hold_lens", 256'({o_seq_ref_length, o_seq_read_length}), 256'({j.rl, j.dl}));
      end
      i_byte_valid = 1'b0;
      handshake("full");

      // Odd lengths 5/1
      ref_bytes[0]  = 8'hA5;
      ref_bytes[1]  = 8'hC0;
      read_bytes[0] = 8'h40;
      send_frame(5, 1, 1'b0);
      pop_check("odd", j);
      handshake("odd");

      // Illegal headers
      put(8'd0);
      i_byte_valid = 1'b0;
      chk("err_h0_zero", 256'(o_err), 256'd1);
      @(negedge clk);
      chk("err_h0_zero_pulse", 256'(o_err), 256'd0);
      put(8'd200);
      i_byte_valid = 1'b0;
      chk("err_h0_200", 256'(o_err), 256'd1);
      @(negedge clk);
      chk("err_h0_200_pulse", 256'(o_err), 256'd0);
      put(8'd3);
      chk("err_h0_3_legal", 256'(o_err), 256'd0);
      put(8'd129);
      i_byte_valid = 1'b0;
      chk("err_h1_129", 256'(o_err), 256'd1);
      @(negedge clk);
      chk("err_h1_129_pulse", 256'(o_err), 256'd0);
      chk("err_no_valid", 256'(o_valid), 256'd0);
      ref_bytes[0]  = 8'h80;
      read_bytes[0] = 8'h30;
      send_frame(2, 2, 1'b0);
      pop_check("after_err", j);
      handshake("after_err");

      // 6/6 back-to-back, then with gaps between bytes
      ref_bytes[0]  = 8'h12;
      ref_bytes[1]  = 8'h34;
      read_bytes[0] = 8'h56;
      read_bytes[1] = 8'h78;
      send_frame(6, 6, 1'b0);
      pop_check("b2b", j);
      handshake("b2b");
      send_frame(6, 6, 1'b1);
      pop_check("gap", j);
      handshake("gap");

      // Reset mid-frame after 20 bytes of a 128/128 frame
      put(8'd128);
      put(8'd128);
      for (int k = 0; k < 18; k++) put(8'(k + 1));
      i_byte_valid = 1'b0;
      chk("mid_ref_byte0", 256'(o_sequence_ref[255:248]), 256'h01);
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      ref_bytes[0]  = 8'h9C;
      read_bytes[0] = 8'h27;
      send_frame(4, 4, 1'b0);
      pop_check("post_rst", j);
      handshake("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
